alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised ALU execute unit with an integrated ALU-control decoder. It decodes `aluOp`/`Funct7`/`Funct3` for the full RV32I integer operation set, plus a subset of the M extension. Single-cycle operations complete in one cycle. Multiply and divide run on iterative XLEN-cycle datapaths. It sits in the EX stage between the main control unit and the memory/writeback stage, with a valid/ready handshake on both sides so the pipeline can stall on multi-cycle operations.

## Interface
- `XLEN`, default 32: operand and result width; must be a power of two, at least 8.
- `ENABLE_M`, default 1: when 0, all `Funct7=0000001` encodings decode as illegal.
- `clk` input 1: single clock; everything updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: unit can accept a request.
- `aluOp` input 2: 00 = load/store address, 01 = branch compare, 10 = R-type, 11 = I-type.
- `Funct7` input 7: instruction funct7 field, or the imm[11:5] field for I-type.
- `Funct3` input 3: instruction funct3 field.
- `operand_a` input XLEN: rs1 value.
- `operand_b` input XLEN: rs2 value or immediate.
- `out_valid` output 1: result is available.
- `out_ready` input 1: consumer takes the result.
- `result` output XLEN: operation result.
- `zero` output 1: high when `result == 0`.
- `illegal` output 1: the request decoded to no supported operation.

## Operation
- **aluOp 00**: ADD. **aluOp 01**: SUB, so `zero` serves BEQ/BNE.
- **aluOp 10, Funct7=0000000**, by Funct3:
  - 000 ADD, 001 SLL, 010 SLT (signed), 011 SLTU
  - 100 XOR, 101 SRL, 110 OR, 111 AND
- **aluOp 10, Funct7=0100000**: 000 SUB, 101 SRA. Any other Funct3 is illegal.
- **aluOp 10, Funct7=0000001** (requires ENABLE_M=1):
  - 000 MUL: low XLEN bits of the product.
  - 011 MULHU: high XLEN bits of the unsigned product.
  - 101 DIVU, 111 REMU.
  - Any other Funct3 is illegal.
- **aluOp 11**: same Funct3 map as the Funct7=0000000 R-type row, except SUB does not exist.
  - Funct7 is checked only for shifts. 001 requires 0000000.
  - 101 with 0000000 is SRL; 101 with 0100000 is SRA; any other Funct7 on a shift is illegal.
- **Shift amount**: `operand_b[log2(XLEN)-1:0]`; upper bits are ignored.
- **Width**: all arithmetic wraps modulo 2^XLEN; no overflow flag.
- **Multiply**: shift-add over XLEN iterations, using a 2·XLEN-bit product register.
- **Divide**: restoring division over XLEN iterations.
- **Divide by zero** completes in single-cycle latency, with no iteration:
  - DIVU result = all ones.
  - REMU result = `operand_a`.
- **Illegal request**: completes in single-cycle latency with `result=0`, `zero=1`, `illegal=1`.
- **State machine**:
  - IDLE: `in_ready=1`. On accept, a multi-cycle op goes to BUSY; anything else goes to DONE with the result registered.
  - BUSY: an iteration counter counts XLEN steps. On the last step the result is registered and the state goes to DONE.
  - DONE: `out_valid=1`. When `out_ready=1` the state returns to IDLE.
- Operands and decoded operation are captured at accept. Input changes after accept have no effect.

## Timing
- **Reset** (asynchronous, applies immediately): state IDLE, `out_valid=0`, `result=0`, `zero=0`, `illegal=0`, counter 0. `in_ready=1` as soon as reset deasserts.
- **Reset mid-operation**: aborts BUSY or DONE; the in-flight result is discarded.
- **Accept** occurs on a rising edge with `in_valid & in_ready`.
- **`in_ready`** is a combinational decode of state (IDLE only). It never depends on `in_valid`.
- **Single-cycle op, illegal, divide by zero**: `out_valid` rises on the edge after the accept edge (latency 1).
- **MUL, MULHU, DIVU, REMU**: `out_valid` rises XLEN+1 edges after accept (33 for XLEN=32).
- **Output stability**: `result`, `zero` and `illegal` are registered and remain stable while `out_valid=1 & out_ready=0`.
- **Retire**: the handshake completes on an edge with `out_valid & out_ready`. The next accept is possible one cycle later, since there is no bypass from DONE to accept.
- **Throughput**: at most one result per 2 cycles for single-cycle ops.

## Test plan
- Reset held with random inputs, then released → `in_ready=1`, `out_valid=0`, `result=0`. Assert `rst` while BUSY → immediate return to IDLE, no `out_valid`.
- R-type SUB, `a=5`, `b=7` → `result=0xFFFFFFFE`, latency 1. Branch `aluOp=01`, `a=b=0x1234` → `zero=1`. SLT `0xFFFFFFFF` vs `1` → 1; SLTU with the same operands → 0.
- I-type SRA, `a=0x80000000`, `b=0x404` (Funct7=0100000) → `0xF8000000`. SLL with Funct7=0100000 → `illegal=1`, `result=0`, `zero=1`.
- MULHU `0xFFFFFFFF × 0xFFFFFFFF` → `0xFFFFFFFE`; MUL with the same operands → `0x00000001`. In both cases `out_valid` asserts exactly 33 cycles after accept and `in_ready=0` throughout.
- DIVU `100/7` → 14 and REMU → 2, latency 33. DIVU by 0 → `0xFFFFFFFF` and REMU `9/0` → 9, latency 1.
- Back-pressure: hold `out_ready=0` for 10 cycles in DONE → `result` stable and `in_ready=0`. Release → retire, then accept on the following cycle. With ENABLE_M=0, MUL → `illegal=1`.

Source files
------------

// File: rtl/alu_exec_if.sv
// Request/response bundle between the EX-stage control and the ALU execute unit.
// Both directions use a valid/ready handshake so the pipeline can stall on multi-cycle ops.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      aluOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, aluOp, Funct7, Funct3, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, aluOp, Funct7, Funct3, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute unit: RV32I integer ops plus MUL/MULHU/DIVU/REMU, with built-in ALU-control decode.
// Single-cycle ops finish at accept; multiply/divide iterate XLEN steps in a shared 2*XLEN accumulator.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_ILL
  } op_t;

  state_t              state;
  op_t                 dec_op;
  op_t                 op_p0;
  logic [SHW-1:0]      cnt;
  logic [2*XLEN-1:0]   acc_p0;
  logic [2*XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]     opb_p0;
  logic [XLEN-1:0]     single_res;
  logic [XLEN-1:0]     fin_res;
  logic [XLEN-1:0]     result_p1;
  logic                vld_p1;
  logic                zero_p1;
  logic                illegal_p1;
  logic                accept;
  logic                is_mul;
  logic                is_multi;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN+1:0]     div_diff;

  function automatic op_t decode(input logic [1:0] aop, input logic [6:0] f7,
                                 input logic [2:0] f3);
    op_t base;
    case (f3)
      3'b000:  base = OP_ADD;
      3'b001:  base = OP_SLL;
      3'b010:  base = OP_SLT;
      3'b011:  base = OP_SLTU;
      3'b100:  base = OP_XOR;
      3'b101:  base = OP_SRL;
      3'b110:  base = OP_OR;
      default: base = OP_AND;
    endcase
    decode = OP_ILL;
    case (aop)
      2'b00: decode = OP_ADD;
      2'b01: decode = OP_SUB;
      2'b10: begin
        if (f7 == 7'b0000000) begin
          decode = base;
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      decode = OP_SUB;
          else if (f3 == 3'b101) decode = OP_SRA;
        end else if (f7 == 7'b0000001 && ENABLE_M) begin
          case (f3)
            3'b000:  decode = OP_MUL;
            3'b011:  decode = OP_MULHU;
            3'b101:  decode = OP_DIVU;
            3'b111:  decode = OP_REMU;
            default: decode = OP_ILL;
          endcase
        end
      end
      default: begin
        // I-type: imm[11:5] only matters for shifts
        if (f3 == 3'b001) begin
          if (f7 == 7'b0000000) decode = OP_SLL;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0000000)      decode = OP_SRL;
          else if (f7 == 7'b0100000) decode = OP_SRA;
        end else begin
          decode = base;
        end
      end
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu_single(input op_t op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu_single = a + b;
      OP_SUB:  alu_single = a - b;
      OP_SLL:  alu_single = a << sh;
      OP_SLT:  alu_single = {{(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLTU: alu_single = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  alu_single = a ^ b;
      OP_SRL:  alu_single = a >> sh;
      OP_SRA:  alu_single = sa >>> sh;
      OP_OR:   alu_single = a | b;
      OP_AND:  alu_single = a & b;
      OP_DIVU: alu_single = '1;
      OP_REMU: alu_single = a;
      default: alu_single = '0;
    endcase
  endfunction

  always_comb begin
    dec_op     = decode(bus.aluOp, bus.Funct7, bus.Funct3);
    single_res = alu_single(dec_op, bus.operand_a, bus.operand_b);
    is_mul     = (dec_op == OP_MUL) || (dec_op == OP_MULHU);
    // a zero divisor takes the single-cycle path, so only nonzero divides iterate
    is_multi   = is_mul ||
                 (((dec_op == OP_DIVU) || (dec_op == OP_REMU)) && (bus.operand_b != '0));
  end

  assign accept = bus.in_valid && (state == S_IDLE);

  // One iteration: shift-add multiply, or restoring divide with remainder in the upper half
  always_comb begin
    mul_sum   = {1'b0, acc_p0[2*XLEN-1:XLEN]} + (acc_p0[0] ? {1'b0, opb_p0} : '0);
    div_shift = {acc_p0[2*XLEN-1:XLEN], acc_p0[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_p0};
    if ((op_p0 == OP_MUL) || (op_p0 == OP_MULHU))
      acc_nxt = {mul_sum, acc_p0[XLEN-1:1]};
    else if (div_diff[XLEN+1])
      acc_nxt = {div_shift[XLEN-1:0], acc_p0[XLEN-2:0], 1'b0};
    else
      acc_nxt = {div_diff[XLEN-1:0], acc_p0[XLEN-2:0], 1'b1};
    case (op_p0)
      OP_MUL:  fin_res = acc_nxt[XLEN-1:0];
      OP_DIVU: fin_res = acc_nxt[XLEN-1:0];
      default: fin_res = acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  // Stage p0: operand/opcode capture at accept, then iteration
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= dec_op;
      opb_p0 <= is_mul ? bus.operand_a : bus.operand_b;
      acc_p0 <= {{XLEN{1'b0}}, (is_mul ? bus.operand_b : bus.operand_a)};
    end else if (state == S_BUSY) begin
      acc_p0 <= acc_nxt;
    end
  end

  // Stage p1: control FSM and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      vld_p1     <= 1'b0;
      result_p1  <= '0;
      zero_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (is_multi) begin
              state <= S_BUSY;
              cnt   <= '0;
            end else begin
              result_p1  <= single_res;
              zero_p1    <= (single_res == '0);
              illegal_p1 <= (dec_op == OP_ILL);
              vld_p1     <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (cnt == SHW'(XLEN-1)) begin
            result_p1  <= fin_res;
            zero_p1    <= (fin_res == '0);
            illegal_p1 <= 1'b0;
            vld_p1     <= 1'b1;
            cnt        <= '0;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            vld_p1 <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = vld_p1;
  assign bus.result    = result_p1;
  assign bus.zero      = zero_p1;
  assign bus.illegal   = illegal_p1;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency, back-pressure and reset cases.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   lat;
  logic rdy_busy;
  logic seen_vld;

  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus ();
  alu_exec_if #(.XLEN(32)) bus_nm ();

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (bus_nm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one request, then scrambles the inputs and waits for out_valid (bounded).
  task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.aluOp     = aop;
    bus.Funct7    = f7;
    bus.Funct3    = f3;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.aluOp     = 2'($urandom);
    bus.Funct7    = 7'($urandom);
    bus.Funct3    = 3'($urandom);
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    lat      = 1;
    rdy_busy = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      rdy_busy |= bus.in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input logic [31:0] res, input logic z,
                            input logic ill, input int exp_lat);
    check({tag, "_res"}, bus.result, res);
    check({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, z});
    check({tag, "_ill"}, {31'b0, bus.illegal}, {31'b0, ill});
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_retire_vld"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_retire_rdy"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid     = 1'($urandom);
      bus.out_ready    = 1'($urandom);
      bus.aluOp        = 2'($urandom);
      bus.Funct7       = 7'($urandom);
      bus.Funct3       = 3'($urandom);
      bus.operand_a    = $urandom;
      bus.operand_b    = $urandom;
      bus_nm.in_valid  = 1'($urandom);
      bus_nm.out_ready = 1'($urandom);
      bus_nm.aluOp     = 2'($urandom);
      bus_nm.Funct7    = 7'($urandom);
      bus_nm.Funct3    = 3'($urandom);
      bus_nm.operand_a = $urandom;
      bus_nm.operand_b = $urandom;
      @(negedge clk);
    end
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus_nm.in_valid  = 1'b0;
    bus_nm.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd0);
    check("rst_illegal", {31'b0, bus.illegal}, 32'd0);

    issue(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd7);
    expect_res("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    retire("sub");

    issue(2'b01, 7'h00, 3'b000, 32'h1234, 32'h1234);
    expect_res("beq", 32'd0, 1'b1, 1'b0, 1);
    retire("beq");

    issue(2'b10, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1);
    expect_res("slt", 32'd1, 1'b0, 1'b0, 1);
    retire("slt");

    issue(2'b10, 7'b0000000, 3'b011, 32'hFFFF_FFFF, 32'd1);
    expect_res("sltu", 32'd0, 1'b1, 1'b0, 1);
    retire("sltu");

    issue(2'b11, 7'b0100000, 3'b101, 32'h8000_0000, 32'h0000_0404);
    expect_res("srai", 32'hF800_0000, 1'b0, 1'b0, 1);
    retire("srai");

    issue(2'b11, 7'b0100000, 3'b001, 32'h0000_00FF, 32'd3);
    expect_res("slli_bad", 32'd0, 1'b1, 1'b1, 1);
    retire("slli_bad");

    issue(2'b11, 7'b1010101, 3'b000, 32'd10, 32'hFFFF_FFFD);
    expect_res("addi", 32'd7, 1'b0, 1'b0, 1);
    retire("addi");

    issue(2'b10, 7'b0000000, 3'b101, 32'h8000_0000, 32'd31);
    expect_res("srl", 32'd1, 1'b0, 1'b0, 1);
    retire("srl");

    issue(2'b10, 7'b0100000, 3'b001, 32'd1, 32'd1);
    expect_res("r_bad", 32'd0, 1'b1, 1'b1, 1);
    retire("r_bad");

    issue(2'b10, 7'b0000001, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_res("mulhu", 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    check("mulhu_busy_rdy", {31'b0, rdy_busy}, 32'd0);
    retire("mulhu");

    issue(2'b10, 7'b0000001, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_res("mul", 32'h0000_0001, 1'b0, 1'b0, 33);
    check("mul_busy_rdy", {31'b0, rdy_busy}, 32'd0);
    retire("mul");

    issue(2'b10, 7'b0000001, 3'b000, 32'd12345, 32'd678);
    expect_res("mul_small", 32'd8369910, 1'b0, 1'b0, 33);
    retire("mul_small");

    issue(2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7);
    expect_res("divu", 32'd14, 1'b0, 1'b0, 33);
    retire("divu");

    issue(2'b10, 7'b0000001, 3'b111, 32'd100, 32'd7);
    expect_res("remu", 32'd2, 1'b0, 1'b0, 33);
    retire("remu");

    issue(2'b10, 7'b0000001, 3'b101, 32'd100, 32'd0);
    expect_res("divu0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    retire("divu0");

    issue(2'b10, 7'b0000001, 3'b111, 32'd9, 32'd0);
    expect_res("remu0", 32'd9, 1'b0, 1'b0, 1);
    retire("remu0");

    issue(2'b00, 7'h00, 3'b000, 32'd3, 32'd4);
    expect_res("bp_add", 32'd7, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_result", bus.result, 32'd7);
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    retire("bp");
    issue(2'b10, 7'b0000000, 3'b100, 32'h0000_F0F0, 32'h0000_0FF0);
    expect_res("bp_next_xor", 32'h0000_FF00, 1'b0, 1'b0, 1);
    retire("bp_next");

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.aluOp     = 2'b10;
    bus.Funct7    = 7'b0000001;
    bus.Funct3    = 3'b000;
    bus.operand_a = 32'd3;
    bus.operand_b = 32'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy_vld", {31'b0, bus.out_valid}, 32'd0);
    check("rst_busy_rdy", {31'b0, bus.in_ready}, 32'd1);
    check("rst_busy_res", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_vld = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen_vld |= bus.out_valid;
    end
    check("rst_busy_no_vld", {31'b0, seen_vld}, 32'd0);

    @(negedge clk);
    bus_nm.in_valid  = 1'b1;
    bus_nm.aluOp     = 2'b10;
    bus_nm.Funct7    = 7'b0000001;
    bus_nm.Funct3    = 3'b000;
    bus_nm.operand_a = 32'd3;
    bus_nm.operand_b = 32'd5;
    @(posedge clk);
    #1;
    bus_nm.in_valid = 1'b0;
    check("nom_mul_vld", {31'b0, bus_nm.out_valid}, 32'd1);
    check("nom_mul_ill", {31'b0, bus_nm.illegal}, 32'd1);
    check("nom_mul_res", bus_nm.result, 32'd0);
    check("nom_mul_zero", {31'b0, bus_nm.zero}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
